// File: rtl/bit_splitter_par.sv
// Serial-to-parallel I/Q splitter: even bit indices feed the I rail and odd
// indices feed the Q rail, each MSB-first. Define GRAY_MAP_EN for Gray-coded rail words.
module bit_splitter_par #(
  parameter int SYM_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data,
  input  logic                    data_valid,
  input  logic                    align,
  output logic                    data_ready,
  output logic [SYM_BITS/2-1:0]   d1,
  output logic [SYM_BITS/2-1:0]   d2,
  output logic                    sym_valid,
  input  logic                    sym_ready
);

  localparam int RW = SYM_BITS / 2;
  localparam int KW = $clog2(SYM_BITS);
  localparam logic [KW-1:0] K_LAST = KW'(SYM_BITS - 1);

  logic [KW-1:0] k_q, k_d, k_eff;
  logic [RW-1:0] i_q, i_d, q_q, q_d, i_base, q_base;
  logic [RW:0]   i_cat, q_cat;
  logic [RW-1:0] d1_q, d1_d, d2_q, d2_d;
  logic          sv_q, sv_d;
  logic          accept;

  function automatic logic [RW-1:0] map_word(input logic [RW-1:0] b);
`ifdef GRAY_MAP_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  always_comb begin
    k_d    = k_q;
    i_d    = i_q;
    q_d    = q_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    sv_d   = sv_q;
    // An aligned bit restarts the symbol, so it shifts into empty rails at k=0.
    k_eff  = align ? '0 : k_q;
    i_base = align ? '0 : i_q;
    q_base = align ? '0 : q_q;
    i_cat  = {i_base, data};
    q_cat  = {q_base, data};
    data_ready = !((k_q == K_LAST) && sv_q && !sym_ready);
    accept = data_valid && data_ready;

    if (sv_q && sym_ready) sv_d = 1'b0;

    if (accept) begin
      if (!k_eff[0]) begin
        i_d = i_cat[RW-1:0];
        q_d = q_base;
      end else begin
        i_d = i_base;
        q_d = q_cat[RW-1:0];
      end
      if (k_eff == K_LAST) begin
        d1_d = map_word(i_d);
        d2_d = map_word(q_d);
        sv_d = 1'b1;
        k_d  = '0;
        i_d  = '0;
        q_d  = '0;
      end else begin
        k_d = k_eff + KW'(1);
      end
    end else if (align) begin
      k_d = '0;
      i_d = '0;
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= '0;
      i_q  <= '0;
      q_q  <= '0;
      d1_q <= '0;
      d2_q <= '0;
      sv_q <= 1'b0;
    end else begin
      k_q  <= k_d;
      i_q  <= i_d;
      q_q  <= q_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      sv_q <= sv_d;
    end
  end

  assign d1        = d1_q;
  assign d2        = d2_q;
  assign sym_valid = sv_q;

endmodule

// File: doc/bit_splitter_par.md
BIT_SPLITTER_PAR -- requirements
Module: bit_splitter_par

Interface
REQ-001 Parameter SYM_BITS, default 2, bits per symbol; SHALL be even, 2..16 (QPSK=2, 16-QAM=4).
REQ-002 Derived width RW = SYM_BITS/2, width of each rail output.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 data  in  1  serial input bit.
REQ-006 data_valid  in  1  data carries a bit this cycle.
REQ-007 align  in  1  symbol-boundary marker; qualified by data_valid when a bit is present.
REQ-008 data_ready  out  1  block accepts data this cycle (combinational).
REQ-009 d1  out  RW  I-rail symbol word.
REQ-010 d2  out  RW  Q-rail symbol word.
REQ-011 sym_valid  out  1  d1/d2 hold an unconsumed symbol.
REQ-012 sym_ready  in  1  downstream accepts symbol; transfer when sym_valid && sym_ready.

Function
REQ-013 A bit SHALL be accepted when data_valid && data_ready.
REQ-014 Bit index k (0..SYM_BITS-1) SHALL be held in a counter; even k routes to the I shift register, odd k to the Q shift register.
REQ-015 Each rail SHALL fill MSB-first: the first I bit of a symbol ends as d1[RW-1]; likewise Q.
REQ-016 On acceptance of bit k=SYM_BITS-1, completed rails SHALL load d1/d2 and set sym_valid at the same edge (latency 1 cycle from last bit to sym_valid visible); the counter SHALL wrap to 0.
REQ-017 sym_valid SHALL clear on the edge where sym_valid && sym_ready, unless a new symbol completes at that edge, in which case it remains 1 with new data.
REQ-018 d1, d2 SHALL remain stable while sym_valid && !sym_ready.
REQ-019 data_ready SHALL be 0 only when k=SYM_BITS-1 and sym_valid && !sym_ready; otherwise 1 (bits 0..SYM_BITS-2 accepted under backpressure).
REQ-020 Continuous data_valid with sym_ready=1 SHALL yield one symbol per SYM_BITS cycles, no bubbles.
REQ-021 align=1 with an accepted bit SHALL treat that bit as k=0; partial bits SHALL be discarded.
REQ-022 align=1 without an accepted bit SHALL clear k to 0 and discard partial bits; d1/d2/sym_valid unaffected.
REQ-023 align on k=0 SHALL have no extra effect.
REQ-024 data_valid=0 SHALL hold all state; no timeout.

Reset
REQ-025 rst=1 at a clock edge SHALL set k=0, shift registers=0, d1=d2=0, sym_valid=0, overriding data, align, sym_ready.
REQ-026 Reset mid-symbol SHALL discard partial bits; the first bit accepted after rst deasserts is k=0.
REQ-027 data_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-028 Macro GRAY_MAP_EN: when defined, d1 and d2 SHALL each be binary-to-Gray converted (g = b XOR (b>>1)) at load; when undefined, natural binary as shifted in.
REQ-029 With SYM_BITS=2 (RW=1) both settings SHALL give identical outputs.

Verification
REQ-030 SYM_BITS=2, sym_ready=1, bits 1,0,1,1 continuous -> symbols (d1=1,d2=0) then (d1=1,d2=1), sym_valid high one cycle each, 2 cycles apart.
REQ-031 SYM_BITS=4, bits 1,0,1,1 -> d1=2'b11, d2=2'b01 without GRAY_MAP_EN; d1=2'b10, d2=2'b01 with it.
REQ-032 SYM_BITS=2, sym_ready=0, bits 1,1,0,0 -> first symbol (1,1) held; data_ready=0 at final bit of second; after sym_ready=1 for one cycle, second bit accepted, next symbol (0,0).
REQ-033 SYM_BITS=4, bits 1,1 then align=1 with bits 0,1,0,0 -> single symbol d1=2'b00, d2=2'b10; partial 1,1 discarded.
REQ-034 SYM_BITS=4, three bits accepted, rst pulsed one cycle, then 0,1,1,0 -> sym_valid=0 during/after reset until symbol d1=2'b01, d2=2'b10.
REQ-035 Completion and sym_ready in same cycle with sym_valid=1 -> sym_valid stays 1, d1/d2 take new symbol, no loss or duplication.
